cla_4bit: RTL and testbench



---
 rtl/cla_4bit.sv | 53 +++++
 tb/tb_cla_4bit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cla_4bit.sv
// Registered 4-bit carry-lookahead adder; leaf cell for wider lookahead trees.
// Exposes registered group propagate/generate for a second-level lookahead unit.
module cla_4bit (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] S,
  output logic       Cout,
  output logic       PG,
  output logic       GG,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic [3:0] sum_d;
  logic       pg_d;
  logic       gg_d;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is a flat sum-of-products so no carry depends on another carry.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign sum_d = p ^ c[3:0];
  assign pg_d  = &p;
  assign gg_d  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= 4'b0000;
      Cout <= 1'b0;
      PG   <= 1'b0;
      GG   <= 1'b0;
    end else begin
      S    <= sum_d;
      Cout <= c[4];
      PG   <= pg_d;
      GG   <= gg_d;
    end
  end

endmodule

// File: tb/tb_cla_4bit.sv
// Self-checking bench for cla_4bit: directed vector table, reset corners,
// and an exhaustive back-to-back sweep against an arithmetic reference.
module tb_cla_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] S;
  logic       Cout;
  logic       PG;
  logic       GG;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;

  int pass_cnt;
  int total_cnt;

  // Packed expectation: {S, Cout, PG, GG}
  logic [6:0] exp_q[$];
  logic       cin_q[$];
  string      name_q[$];

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       pg;
    logic       gg;
  } vec_t;

  vec_t vecs[10];

  cla_4bit dut (
    .clk  (clk),
    .rst  (rst),
    .S    (S),
    .Cout (Cout),
    .PG   (PG),
    .GG   (GG),
    .A    (A),
    .B    (B),
    .Cin  (Cin)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got S/Cout/PG/GG=%b, want %b", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  // Scoreboard pop: compares the result registered at the preceding rising edge.
  task automatic pop_check();
    logic [6:0] e;
    logic       ci;
    string      n;
    e  = exp_q.pop_front();
    ci = cin_q.pop_front();
    n  = name_q.pop_front();
    check(n, {S, Cout, PG, GG}, e);
    check_bit({n, " invariant"}, Cout, GG | (PG & ci));
    check_bit({n, " pg_gg_excl"}, PG & GG, 1'b0);
  endtask

  // Driver: one vector per cycle, checked one cycle after it is applied.
  task automatic step(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic cin, input logic [6:0] exp);
    @(negedge clk);
    if (exp_q.size() > 0) pop_check();
    A   = a;
    B   = b;
    Cin = cin;
    exp_q.push_back(exp);
    cin_q.push_back(cin);
    name_q.push_back(name);
  endtask

  task automatic flush();
    @(negedge clk);
    if (exp_q.size() > 0) pop_check();
  endtask

  initial begin
    logic [4:0] total;
    logic [4:0] ab;
    logic [6:0] exp;

    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{"basic_1",     4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"basic_7",     4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"gen_13_10_1", 4'b1101, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"gen_14_9_0",  4'b1110, 4'b1001, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"gen_15_10_0", 4'b1111, 4'b1010, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"prop_cin1",   4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"prop_cin0",   4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"zero",        4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"mid_3_4_1",   4'b0011, 4'b0100, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"wrap_max",    4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};

    // Reset held with all-ones inputs while the clock toggles.
    rst = 1'b1;
    A   = 4'b1111;
    B   = 4'b1111;
    Cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_hold", {S, Cout, PG, GG}, 7'b0);
    end
    rst = 1'b0;

    // Directed table, back-to-back.
    for (int i = 0; i < 10; i++)
      step(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin,
           {vecs[i].s, vecs[i].cout, vecs[i].pg, vecs[i].gg});
    flush();

    // Outputs now hold the nonzero wrap_max result; reset must clear them without an edge.
    #2 rst = 1'b1;
    #1 check("async_reset", {S, Cout, PG, GG}, 7'b0);
    A   = 4'b0110;
    B   = 4'b0110;
    Cin = 1'b1;
    @(negedge clk);
    check("reset_held_edge", {S, Cout, PG, GG}, 7'b0);

    // Release mid-cycle: the next edge captures the current inputs (6+6+1=13).
    rst = 1'b0;
    @(negedge clk);
    check("first_after_reset", {S, Cout, PG, GG}, {4'b1101, 1'b0, 1'b0, 1'b0});

    // Exhaustive back-to-back sweep against arithmetic reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ab    = 5'(a) + 5'(b);
          total = ab + 5'(ci);
          // Group propagate: operands sum to exactly 15; generate: they overflow alone.
          exp   = {total[3:0], total[4], (ab == 5'd15), (ab >= 5'd16)};
          step($sformatf("exh_%0d_%0d_%0d", a, b, ci), 4'(a), 4'(b), 1'(ci), exp);
        end
      end
    end
    flush();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
